fwd_scoreboard_unit: RTL
========================

// Module: fwd_scoreboard_unit
// PURPOSE
//  Parametrised forwarding/hazard scoreboard for deeper pipelines. Tracks in-flight register
//  writers in NUM_FWD_STAGES stages after EX; each carries a result-ready countdown.
//  Per EX source it selects the youngest matching producer, or stalls when that result is not
//  ready (load-use, multi-cycle). Inserts a bubble on stall, supports flush, counts stalls.
// PARAMETERS
//  NUM_FWD_STAGES  2   tracked stages after EX (index 1 = youngest)
//  NUM_SRC         2   source operands per consumer
//  REG_ADDR_W      5   register address width
//  MAX_LAT         4   max extra result latency in cycles; LAT_W = $clog2(MAX_LAT+1)
//  FLUSH_DEPTH     1   youngest entries killed by flush (1..NUM_FWD_STAGES)
//  SEL_W = $clog2(NUM_FWD_STAGES+1)
// PORTS
//  CLK          in   1                      clock
//  nRST         in   1                      async active-low reset
//  advance      in   1                      pipeline shifts one stage this cycle
//  flush        in   1                      kill youngest FLUSH_DEPTH entries
//  ex_valid     in   1                      valid instruction in EX
//  ex_reg_write in   1                      EX instruction writes rd
//  ex_rd        in   REG_ADDR_W             EX destination
//  ex_lat       in   LAT_W                  extra cycles until EX result forwardable (0 = ALU)
//  rs_used      in   NUM_SRC                source i actually read
//  rs_addr      in   NUM_SRC*REG_ADDR_W     source addresses of consumer in EX
//  fwd_sel      out  NUM_SRC*SEL_W          0 = regfile, k = forward from tracked stage k
//  fwd_hit      out  NUM_SRC                fwd_sel nonzero and valid
//  stall        out  1                      consumer must hold in EX
//  stall_count  out  32                     saturating count of stall cycles
// BEHAVIOUR
//  - Entry k: {valid, rd, cnt[LAT_W]}. Reset (async): all invalid, cnt 0, stall_count 0.
//    fwd_sel/fwd_hit/stall are combinational from entries, so all outputs are 0 in reset.
//  - Every cycle each valid entry's cnt decrements, saturating at 0, regardless of advance.
//  - advance=1: entry[k] <= entry[k-1] (decremented); entry[NUM_FWD_STAGES] retires
//    (regfile write-through is handled externally).
//    entry[1] <= {ex_valid & ex_reg_write & ex_rd!=0 & !stall, ex_rd, min(ex_lat,MAX_LAT)}.
//    With stall=1, entry[1] is a bubble.
//  - advance=0: entries hold position; counters still decrement.
//  - flush: after the shift/hold above, entries 1..FLUSH_DEPTH are forced invalid.
//    flush together with advance kills the incoming EX instruction too.
//  - Source i matches entry k when rs_used[i], entry valid, rd==rs_addr[i], rs_addr[i]!=0.
//    The lowest k wins (youngest producer).
//    Winner cnt==0: fwd_sel=k, fwd_hit=1.
//    Winner cnt!=0: fwd_sel=0, fwd_hit=0, and this source raises stall.
//    An older ready match never overrides a younger unready one.
//  - stall = OR over sources. stall_count += 1 each cycle stall=1, holds at 2^32-1.
//  - Zero-cycle latency from rs_addr to outputs; one cycle from ex_* to visibility.
// STRUCTURE
//  - Package fwd_scoreboard_pkg: typedef fwd_entry_t {valid, rd, cnt}; width localparams.
//  - Sub-module fwd_src_match: one per source (generate). Pure priority matcher over the
//    entry array -> {sel, hit, stall_req}. Entry array and stall counter live in the top.
// TESTING (NUM_FWD_STAGES=2, FLUSH_DEPTH=1)
//  1. ALU chain: issue rd=5 lat=0 with advance; next cycle rs_addr[0]=5
//     -> fwd_sel[0]=1, fwd_hit[0]=1, stall=0.
//  2. Load-use: issue rd=7 lat=1 with advance; next cycle rs_addr[1]=7 -> stall=1.
//     Advance inserts a bubble; next cycle -> fwd_sel[1]=2, stall=0; stall_count=1.
//  3. Youngest wins: rd=3 issued in two consecutive advances; rs_addr[0]=3
//     -> fwd_sel[0]=1, not 2.
//  4. x0 / unused: issue rd=0 lat=3; rs_addr[0]=0 -> fwd_sel=0, stall=0.
//     rs_used[1]=0 with a matching address -> fwd_hit[1]=0.
//  5. Flush: issue rd=9 with advance+flush; next cycle rs_addr[0]=9 -> fwd_sel=0, stall=0.
//     Entry at stage 2 stays forwardable.
//  6. Reset mid-op: nRST low with a cnt=3 entry and stall=1 -> stall=0, fwd_hit=0 and
//     stall_count=0 asynchronously; after release rs_addr matching the old rd -> fwd_sel=0.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg
//   Shared definitions for the forwarding/hazard scoreboard.
//   Provides the default configuration constants and the layout of one
//   tracked pipeline entry (valid, destination register, ready countdown)
//   for the default configuration.
package fwd_scoreboard_pkg;

   localparam int unsigned DEF_NUM_FWD_STAGES = 2;
   localparam int unsigned DEF_NUM_SRC        = 2;
   localparam int unsigned DEF_REG_ADDR_W     = 5;
   localparam int unsigned DEF_MAX_LAT        = 4;
   localparam int unsigned DEF_FLUSH_DEPTH    = 1;
   localparam int unsigned DEF_LAT_W          = $clog2(DEF_MAX_LAT + 1);
   localparam int unsigned DEF_SEL_W          = $clog2(DEF_NUM_FWD_STAGES + 1);

   typedef struct packed {
      logic                      valid;
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic [DEF_LAT_W-1:0]      cnt;
   } fwd_entry_t;

endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match
//   Priority matcher for one EX source operand against the tracked entries.
//   Entry k (1 = youngest) is presented at bit/slice k-1 of the flat vectors.
// Ports
//   rs_used    in   source is actually read
//   rs_addr    in   source register address
//   ent_valid  in   per-entry valid
//   ent_ready  in   per-entry result forwardable (countdown reached 0)
//   ent_rd     in   per-entry destination, concatenated
//   sel        out  0 = regfile, k = forward from tracked stage k
//   hit        out  forwarding from a tracked stage
//   stall_req  out  youngest matching producer is not ready yet
module fwd_src_match
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
   parameter int unsigned REG_ADDR_W     = DEF_REG_ADDR_W,
   parameter int unsigned SEL_W          = DEF_SEL_W
) (
   input  logic                                 rs_used,
   input  logic [REG_ADDR_W-1:0]                rs_addr,
   input  logic [NUM_FWD_STAGES-1:0]            ent_valid,
   input  logic [NUM_FWD_STAGES-1:0]            ent_ready,
   input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] ent_rd,
   output logic [SEL_W-1:0]                     sel,
   output logic                                 hit,
   output logic                                 stall_req
);

   // Scan oldest to youngest so the youngest match is written last and wins;
   // an older ready producer can never mask a younger unready one.
   always_comb begin
      sel       = '0;
      hit       = 1'b0;
      stall_req = 1'b0;
      for (int unsigned k = NUM_FWD_STAGES; k >= 1; k--) begin
         if (rs_used && ent_valid[k-1] && (rs_addr != '0) &&
             (ent_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
            if (ent_ready[k-1]) begin
               sel       = SEL_W'(k);
               hit       = 1'b1;
               stall_req = 1'b0;
            end else begin
               sel       = '0;
               hit       = 1'b0;
               stall_req = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit
//   Forwarding/hazard scoreboard. Tracks in-flight register writers in
//   NUM_FWD_STAGES stages after EX, each with a result-ready countdown, and
//   per EX source selects the youngest matching producer or stalls.
// Ports
//   CLK, nRST     clock, async active-low reset
//   advance       pipeline shifts one stage this cycle
//   flush         kill youngest FLUSH_DEPTH entries (including incoming EX)
//   ex_valid, ex_reg_write, ex_rd, ex_lat   instruction currently in EX
//   rs_used, rs_addr                        consumer sources in EX
//   fwd_sel, fwd_hit, stall                 forwarding / hazard decision
//   stall_count   saturating count of stall cycles
module fwd_scoreboard_unit
   import fwd_scoreboard_pkg::*;
#(
   parameter  int unsigned NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
   parameter  int unsigned NUM_SRC        = DEF_NUM_SRC,
   parameter  int unsigned REG_ADDR_W     = DEF_REG_ADDR_W,
   parameter  int unsigned MAX_LAT        = DEF_MAX_LAT,
   parameter  int unsigned FLUSH_DEPTH    = DEF_FLUSH_DEPTH,
   localparam int unsigned LAT_W          = $clog2(MAX_LAT + 1),
   localparam int unsigned SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic                          CLK,
   input  logic                          nRST,
   input  logic                          advance,
   input  logic                          flush,
   input  logic                          ex_valid,
   input  logic                          ex_reg_write,
   input  logic [REG_ADDR_W-1:0]         ex_rd,
   input  logic [LAT_W-1:0]              ex_lat,
   input  logic [NUM_SRC-1:0]            rs_used,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_addr,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
   output logic [NUM_SRC-1:0]            fwd_hit,
   output logic                          stall,
   output logic [31:0]                   stall_count
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [LAT_W-1:0]      cnt;
   } entry_t;

   entry_t ent_q [NUM_FWD_STAGES:1];
   entry_t ent_d [NUM_FWD_STAGES:1];

   logic [NUM_FWD_STAGES-1:0]            ent_valid;
   logic [NUM_FWD_STAGES-1:0]            ent_ready;
   logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] ent_rd;
   logic [NUM_SRC-1:0]                   stall_req;
   logic [LAT_W-1:0]                     lat_clip;

   function automatic logic [LAT_W-1:0] dec_cnt(input logic [LAT_W-1:0] c);
      return (c == '0) ? '0 : c - LAT_W'(1);
   endfunction

   assign lat_clip = (ex_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : ex_lat;

   always_comb begin
      for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
         ent_valid[k-1]                          = ent_q[k].valid;
         ent_ready[k-1]                          = (ent_q[k].cnt == '0);
         ent_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W] = ent_q[k].rd;
      end
   end

   // Countdowns tick every cycle; position only moves on advance. A stalled
   // consumer leaves a bubble in stage 1, and flush is applied last so it
   // also catches the instruction entering from EX.
   always_comb begin
      for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
         ent_d[k]     = ent_q[k];
         ent_d[k].cnt = dec_cnt(ent_q[k].cnt);
      end
      if (advance) begin
         for (int unsigned k = 2; k <= NUM_FWD_STAGES; k++) begin
            ent_d[k]     = ent_q[k-1];
            ent_d[k].cnt = dec_cnt(ent_q[k-1].cnt);
         end
         ent_d[1].valid = ex_valid & ex_reg_write & (ex_rd != '0) & ~stall;
         ent_d[1].rd    = ex_rd;
         ent_d[1].cnt   = lat_clip;
      end
      if (flush) begin
         for (int unsigned k = 1; k <= FLUSH_DEPTH; k++) begin
            ent_d[k].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
            ent_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
            ent_q[k] <= ent_d[k];
         end
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
         .NUM_FWD_STAGES (NUM_FWD_STAGES),
         .REG_ADDR_W     (REG_ADDR_W),
         .SEL_W          (SEL_W)
      ) u_match (
         .rs_used   (rs_used[i]),
         .rs_addr   (rs_addr[i*REG_ADDR_W +: REG_ADDR_W]),
         .ent_valid (ent_valid),
         .ent_ready (ent_ready),
         .ent_rd    (ent_rd),
         .sel       (fwd_sel[i*SEL_W +: SEL_W]),
         .hit       (fwd_hit[i]),
         .stall_req (stall_req[i])
      );
   end

   assign stall = |stall_req;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

endmodule
